dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RV32 core. It is the memory-side end of the core's data port: it accepts one load/store request at a time, inserts a configurable number of wait states, performs the access on a word-wide array, and returns read data or an error. It replaces the zero-latency combinational data memory so the core's memory-stage stall logic can be exercised against realistic latency.

## Interface
Parameters:
- DEPTH_WORDS, 256: array size in 32-bit words; a power of 2, at least 4.
- WAIT_CYCLES, 1: wait states between acceptance and access; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears FSM and outputs, not array contents.
- req_valid  in  1  request present.
- req_we  in  1  1 means store, 0 means load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte-lane enables for stores; bit i selects req_wdata[8i+7:8i].
- req_ready  out  1  responder can accept a request; reset value 1.
- rsp_valid  out  1  response present; reset value 0.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors; reset value 0.
- rsp_err  out  1  access rejected; reset value 0.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid && req_ready. The responder latches we, addr, wdata and be.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT:
  - req_ready=0. A down-counter is loaded with WAIT_CYCLES-1 at acceptance.
  - When the counter reaches 0, the access executes and the state moves to RESP.
- Access, on the edge entering RESP:
  - Error conditions: addr[1:0]!=0, or addr[31:2] >= DEPTH_WORDS. On error, rsp_err=1, rsp_rdata=0 and the array is unchanged.
  - Load: rsp_rdata = array[addr[31:2]], always the full word.
  - Store: enabled lanes of array[addr[31:2]] are written; rsp_rdata=0.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake the next state is IDLE and rsp_valid, rsp_err and rsp_rdata clear to 0.
- req_valid is ignored outside IDLE. A requester that holds req_valid is accepted once the responder returns to IDLE.
- A store with req_be=0 is legal. It writes nothing and responds normally with rsp_err=0.

## Timing
- Acceptance in cycle t gives rsp_valid=1 in cycle t+1+WAIT_CYCLES.
- Response handshake in cycle r gives req_ready=1 in cycle r+1. A request can be accepted in cycle r+1.
- Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- There is no combinational path from inputs to req_ready or rsp_*. All outputs are registered or decoded only from the FSM state.
- Reset asserted in WAIT aborts the request. The array is unchanged because the write happens only on the RESP-entry edge.
- Reset asserted in RESP drops the response. A store already committed remains committed.
- Reset asserted on the same edge as an access commit: reset wins and no write occurs.
- Array contents are undefined after power-up and are not cleared by reset.

## Configuration
- Macro DMEM_BYTE_WRITE_EN.
- Defined: req_be gates each byte lane as described above. Sub-word stores (sb/sh) are supported.
- Undefined: req_be is ignored and every non-error store writes all 4 bytes. The port remains present so the interface is identical in both builds.

## Structure
- dmem_pkg holds:
  - the dmem_state_t enum (IDLE, WAIT, RESP);
  - the WAIT counter width constant (4 bits);
  - the localparam function computing the address index width from DEPTH_WORDS.
- Sub-module dmem_array holds the synchronous-write, synchronous-read word storage.
  - Ports: clk, we, be[3:0], idx, wd, rd.
  - Byte-lane masking is inside this sub-module.
  - The FSM and error decode are in dmem_responder.

## Test plan
- Reset, then check outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. With WAIT_CYCLES=1, store 0xDEADBEEF to 0x10 accepted at cycle t: rsp_valid=1 at t+2, rsp_err=0. Load 0x10 then returns 0xDEADBEEF.
- With DMEM_BYTE_WRITE_EN: word 0x10 holds 0xDEADBEEF; store 0x000000AA with be=4'b0001, then load 0x10: rsp_rdata=0xDEADBEAA. Without the macro the same sequence reads 0x000000AA.
- Load 0x12 (misaligned) gives rsp_err=1 and rsp_rdata=0. Store to 4*DEPTH_WORDS gives rsp_err=1, and a following load of 0x0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid and rsp_rdata stay stable and req_ready stays 0 with req_valid held high. After the handshake, the next request is accepted one cycle later.
- Reset during WAIT of a store of 0x12345678 to 0x20 (word preloaded with 0x0): the FSM returns to IDLE and a subsequent load of 0x20 returns 0x0.
- WAIT_CYCLES=0: acceptance at t gives rsp_valid at t+1. Back-to-back loads with rsp_ready=1 are accepted every 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state
// encoding, wait-counter width and array index width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int CNT_W = 4;

  function automatic int idx_width(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's data port (master) and the
// data-memory responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word-wide storage with synchronous write (per-byte lane masking) and
// synchronous read. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wd,
  output logic [31:0]      rd
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
    rd_q <= mem_q[idx];
  end

  assign rd = rd_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// access on the RESP-entry edge. Build option: DMEM_BYTE_WRITE_EN enables req_be lane masking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             rdsel_q, rdsel_d;

  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;

  logic             access;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic             acc_err;
  logic             arr_we;
  logic [3:0]       arr_be;
  logic [31:0]      arr_rd;

  // With zero wait states the access happens on the accept edge, so the
  // live request feeds the array; otherwise the latched copy does.
  assign acc_we    = (state_q == IDLE) ? bus.req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign acc_be    = (state_q == IDLE) ? bus.req_be    : be_q;

  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));

`ifdef DMEM_BYTE_WRITE_EN
  assign arr_be = acc_be;
`else
  logic unused_be;
  assign arr_be    = 4'hF;
  assign unused_be = ^acc_be;
`endif

  // Reset on the commit edge must suppress the write.
  assign arr_we = access && acc_we && !acc_err && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdsel_d = rdsel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    access  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          rdsel_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (access) begin
      err_d   = acc_err;
      rdsel_d = !acc_we && !acc_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdsel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdsel_q <= rdsel_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk (clk),
    .we  (arr_we),
    .be  (arr_be),
    .idx (acc_addr[IDX_W+1:2]),
    .wd  (acc_wdata),
    .rd  (arr_rd)
  );

  // The array read register only matters for a successful load.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdsel_q ? arr_rd : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with one wait state and
// one with none, both checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 16;
`ifdef DMEM_BYTE_WRITE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if b1();
  dmem_responder_if b0();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int   tests = 0;
  int   fails = 0;
  rsp_t q1[$];
  rsp_t q0[$];
  rsp_t e1, e0;
  logic [31:0] model [2][DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: misaligned or beyond the array is an error; loads return the
  // whole word; stores merge enabled bytes (all bytes when lane enables are off).
  function automatic rsp_t ref_access(input int d, input logic we, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [3:0] be);
    rsp_t r;
    int   w;
    r = '0;
    if ((addr % 4) != 0 || (addr / 4) >= DEPTH) begin
      r.err = 1'b1;
    end else begin
      w = int'(addr / 4);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i] || !BYTE_EN) model[d][w][8*i +: 8] = wd[8*i +: 8];
      end else begin
        r.rdata = model[d][w];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 6)       return 32'($urandom_range(0, DEPTH-1)) << 2;
    else if (k == 6) return (32'($urandom_range(0, DEPTH-1)) << 2) + 32'($urandom_range(1, 3));
    else if (k == 7) return 32'(DEPTH*4) + (32'($urandom_range(0, 3)) << 2);
    else if (k == 8) return 32'(DEPTH*4 - 4);
    else             return 32'($urandom);
  endfunction

  // Monitors: compare every accepted response against the scoreboard.
  always @(negedge clk) begin
    if (b1.rsp_valid && b1.rsp_ready) begin
      if (q1.size() == 0) check("dut1 spurious rsp", 32'(q1.size()), 32'd1);
      else begin
        e1 = q1.pop_front();
        check("dut1 rdata", b1.rsp_rdata, e1.rdata);
        check1("dut1 err", b1.rsp_err, e1.err);
      end
    end
    if (b0.rsp_valid && b0.rsp_ready) begin
      if (q0.size() == 0) check("dut0 spurious rsp", 32'(q0.size()), 32'd1);
      else begin
        e0 = q0.pop_front();
        check("dut0 rdata", b0.rsp_rdata, e0.rdata);
        check1("dut0 err", b0.rsp_err, e0.err);
      end
    end
  end

  task automatic wait_neg1(input bit for_rsp, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = for_rsp ? b1.rsp_valid : b1.req_ready;
    end
    check1(for_rsp ? "dut1 rsp wait" : "dut1 accept wait", ok, 1'b1);
  endtask

  // One complete transaction on dut1; called and returns just after a rising edge.
  task automatic req1(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int hold);
    int t_acc;
    bit ok;
    b1.req_valid = 1'b1;
    b1.req_we    = we;
    b1.req_addr  = a;
    b1.req_wdata = wd;
    b1.req_be    = be;
    b1.rsp_ready = (hold == 0);
    wait_neg1(1'b0, ok);
    if (!ok) begin
      b1.req_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    q1.push_back(ref_access(0, we, a, wd, be));
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    wait_neg1(1'b1, ok);
    if (!ok) return;
    check("dut1 latency", 32'(cyc - t_acc), 32'd2);
    for (int i = 0; i < hold; i++) begin
      check1("dut1 hold valid", b1.rsp_valid, 1'b1);
      check("dut1 hold rdata", b1.rsp_rdata, q1[0].rdata);
      check1("dut1 hold err", b1.rsp_err, q1[0].err);
      check1("dut1 hold req_ready", b1.req_ready, 1'b0);
      @(posedge clk); #1;
      if (i == hold - 1) b1.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic set0(input int k);
    if (k < DEPTH) begin
      b0.req_we    = 1'b1;
      b0.req_addr  = 32'(k) << 2;
      b0.req_wdata = $urandom;
      b0.req_be    = 4'hF;
    end else begin
      b0.req_we    = 1'($urandom_range(0, 1));
      b0.req_addr  = rand_addr();
      b0.req_wdata = $urandom;
      b0.req_be    = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc_n, last_acc, guard;
    bit  ok;
    reset = 1'b1;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    b1.req_be = 4'h0; b1.rsp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b0.req_be = 4'h0; b0.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("reset req_ready", b1.req_ready, 1'b1);
    check1("reset rsp_valid", b1.rsp_valid, 1'b0);
    check("reset rsp_rdata", b1.rsp_rdata, 32'h0);
    check1("reset rsp_err", b1.rsp_err, 1'b0);
    check1("reset dut0 req_ready", b0.req_ready, 1'b1);
    check1("reset dut0 rsp_valid", b0.rsp_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Zero wait states: back-to-back traffic with rsp_ready tied high.
    acc_n = 0; last_acc = -10; guard = 0;
    b0.req_valid = 1'b1;
    b0.rsp_ready = 1'b1;
    set0(0);
    while (acc_n < DEPTH + 60 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (b0.rsp_valid) check("dut0 latency", 32'(cyc - last_acc), 32'd1);
      if (b0.req_ready) begin
        if (acc_n > 0) check("dut0 spacing", 32'(cyc - last_acc), 32'd2);
        q0.push_back(ref_access(1, b0.req_we, b0.req_addr, b0.req_wdata, b0.req_be));
        last_acc = cyc;
        acc_n++;
        @(posedge clk); #1;
        set0(acc_n);
      end
    end
    b0.req_valid = 1'b0;
    check("dut0 ops done", 32'(acc_n), 32'(DEPTH + 60));
    repeat (3) @(posedge clk);
    #1;

    // dut1: zero the whole array, then the directed scenarios.
    for (int k = 0; k < DEPTH; k++) req1(1'b1, 32'(k) << 2, 32'h0, 4'hF, 0);
    req1(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    req1(1'b0, 32'h10, 32'h0, 4'hF, 0);
    req1(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
    req1(1'b0, 32'h10, 32'h0, 4'hF, 0);
    req1(1'b0, 32'h12, 32'h0, 4'hF, 0);
    req1(1'b1, 32'h0, 32'h55AA55AA, 4'hF, 0);
    req1(1'b1, 32'(DEPTH*4), 32'hFFFFFFFF, 4'hF, 0);
    req1(1'b0, 32'h0, 32'h0, 4'hF, 0);
    req1(1'b1, 32'h14, 32'hCAFEF00D, 4'b0000, 0);
    req1(1'b0, 32'h14, 32'h0, 4'hF, 0);

    // Backpressure for 5 cycles while the next request is already held.
    b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 32'h10;
    b1.req_wdata = 32'h0; b1.req_be = 4'hF; b1.rsp_ready = 1'b0;
    wait_neg1(1'b0, ok);
    if (ok) q1.push_back(ref_access(0, 1'b0, 32'h10, 32'h0, 4'hF));
    @(posedge clk); #1;
    b1.req_addr = 32'h0;
    wait_neg1(1'b1, ok);
    for (int i = 0; i < 5; i++) begin
      check1("bp rsp_valid", b1.rsp_valid, 1'b1);
      check("bp rsp_rdata", b1.rsp_rdata, (q1.size() > 0) ? q1[0].rdata : 32'h0);
      check1("bp req_ready", b1.req_ready, 1'b0);
      @(posedge clk); #1;
      if (i < 4) @(negedge clk);
    end
    b1.rsp_ready = 1'b1;
    @(negedge clk);
    check1("bp req_ready at handshake", b1.req_ready, 1'b0);
    @(negedge clk);
    check1("bp accept next cycle", b1.req_ready, 1'b1);
    if (b1.req_ready) q1.push_back(ref_access(0, 1'b0, 32'h0, 32'h0, 4'hF));
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    wait_neg1(1'b1, ok);
    @(posedge clk); #1;

    // Reset while a store sits in WAIT: nothing may be written.
    req1(1'b1, 32'h20, 32'h0, 4'hF, 0);
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 32'h20;
    b1.req_wdata = 32'h12345678; b1.req_be = 4'hF; b1.rsp_ready = 1'b1;
    wait_neg1(1'b0, ok);
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check1("wait-reset req_ready", b1.req_ready, 1'b1);
    check1("wait-reset rsp_valid", b1.rsp_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    req1(1'b0, 32'h20, 32'h0, 4'hF, 0);

    // Randomised traffic with random response backpressure.
    for (int n = 0; n < 150; n++)
      req1(1'($urandom_range(0, 1)), rand_addr(), 32'($urandom),
           4'($urandom_range(0, 15)), $urandom_range(0, 3));

    repeat (4) @(posedge clk);
    #1;
    check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
    check("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
